// File: rtl/or1k_spr_pkg.sv
// Shared definitions for the OR1K SPR arbiter slice.
//   - spr_state_e : arbiter FSM states
//   - SPR_*       : group-0 local register indices (addr[10:0])
//   - CPU / DU    : requester port indices
//   - is_local()  : true when an SPR address is served from group-0 inputs
package or1k_spr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCAL = 2'd1,
    BUS   = 2'd2,
    RESP  = 2'd3
  } spr_state_e;

  localparam logic [3:0] SPR_VR       = 4'd0;
  localparam logic [3:0] SPR_UPR      = 4'd1;
  localparam logic [3:0] SPR_CPUCFGR  = 4'd2;
  localparam logic [3:0] SPR_DMMUCFGR = 4'd3;
  localparam logic [3:0] SPR_IMMUCFGR = 4'd4;
  localparam logic [3:0] SPR_DCCFGR   = 4'd5;
  localparam logic [3:0] SPR_ICCFGR   = 4'd6;
  localparam logic [3:0] SPR_DCFGR    = 4'd7;
  localparam logic [3:0] SPR_PCCFGR   = 4'd8;
  localparam logic [3:0] SPR_VR2      = 4'd9;
  localparam logic [3:0] SPR_AVR      = 4'd10;

  localparam logic CPU = 1'b0;
  localparam logic DU  = 1'b1;

  // Group 0, index 0..10 is answered locally; everything else goes to the bus.
  function automatic logic is_local(input logic [15:0] addr);
    return (addr[15:11] == 5'd0) && (addr[10:0] <= 11'd10);
  endfunction

endpackage

// File: rtl/or1k_spr_rr_arb.sv
// Two-request round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req[1:0]   : request vector, bit CPU / bit DU
//   done       : strobe marking completion of the granted transaction
//   done_idx   : port that just completed; becomes the last-grant record
//   gnt[1:0]   : one-hot grant (combinational), zero when no request
module or1k_spr_rr_arb
  import or1k_spr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_idx,
  output logic [1:0] gnt
);

  logic last;

  // On a tie the port not served last wins; a lone requester always wins.
  always_comb begin
    gnt = req;
    if (req[CPU] && req[DU])
      gnt = (last == DU) ? 2'b01 : 2'b10;
  end

  // Reset to DU so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last <= DU;
    else if (done) last <= done_idx;
  end

endmodule

// File: rtl/or1k_spr_arbiter.sv
// SPR access arbiter between the CPU pipeline and the debug unit.
// Group-0 configuration registers (index 0..10) are answered locally from the
// spr_* inputs (read-only; writes return err). All other addresses go to the
// downstream SPR bus with a timeout of OPTION_SPR_TIMEOUT bus cycles.
//   clk, rst_n        : clock, async active-low reset
//   cpu_* / du_*      : request (req/we/addr/wdata) and pulse response (ack/err/rdata)
//   spr_vr .. spr_avr : group-0 configuration values
//   spr_bus_*         : registered downstream bus (stb/we/addr/dat out, ack/dat in)
module or1k_spr_arbiter
  import or1k_spr_pkg::*;
#(
  parameter int OPTION_SPR_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_ack_o,
  output logic        cpu_err_o,
  output logic [31:0] cpu_rdata_o,
  input  logic        du_req_i,
  input  logic        du_we_i,
  input  logic [15:0] du_addr_i,
  input  logic [31:0] du_wdata_i,
  output logic        du_ack_o,
  output logic        du_err_o,
  output logic [31:0] du_rdata_o,
  input  logic [31:0] spr_vr,
  input  logic [31:0] spr_upr,
  input  logic [31:0] spr_cpucfgr,
  input  logic [31:0] spr_dmmucfgr,
  input  logic [31:0] spr_immucfgr,
  input  logic [31:0] spr_dccfgr,
  input  logic [31:0] spr_iccfgr,
  input  logic [31:0] spr_dcfgr,
  input  logic [31:0] spr_pccfgr,
  input  logic [31:0] spr_vr2,
  input  logic [31:0] spr_avr,
  output logic        spr_bus_stb_o,
  output logic        spr_bus_we_o,
  output logic [15:0] spr_bus_addr_o,
  output logic [31:0] spr_bus_dat_o,
  input  logic        spr_bus_ack_i,
  input  logic [31:0] spr_bus_dat_i
);

  // Abort fires in the BUS cycle where the counter would reach the limit,
  // so stb stays high for exactly OPTION_SPR_TIMEOUT cycles.
  localparam logic [15:0] TO_LAST = 16'(OPTION_SPR_TIMEOUT - 1);

  spr_state_e  state;
  logic [1:0]  gnt;
  logic        gnt_idx;
  logic        we_q;
  logic [3:0]  lidx_q;
  logic [15:0] cnt;

  logic        sel_we;
  logic [15:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] local_val;
  logic        resp_fire;
  logic        resp_err;
  logic [31:0] resp_rdata;

  or1k_spr_rr_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({du_req_i, cpu_req_i}),
    .done     (state == RESP),
    .done_idx (gnt_idx),
    .gnt      (gnt)
  );

  always_comb begin
    sel_we    = gnt[DU] ? du_we_i    : cpu_we_i;
    sel_addr  = gnt[DU] ? du_addr_i  : cpu_addr_i;
    sel_wdata = gnt[DU] ? du_wdata_i : cpu_wdata_i;
  end

  always_comb begin
    case (lidx_q)
      SPR_VR:       local_val = spr_vr;
      SPR_UPR:      local_val = spr_upr;
      SPR_CPUCFGR:  local_val = spr_cpucfgr;
      SPR_DMMUCFGR: local_val = spr_dmmucfgr;
      SPR_IMMUCFGR: local_val = spr_immucfgr;
      SPR_DCCFGR:   local_val = spr_dccfgr;
      SPR_ICCFGR:   local_val = spr_iccfgr;
      SPR_DCFGR:    local_val = spr_dcfgr;
      SPR_PCCFGR:   local_val = spr_pccfgr;
      SPR_VR2:      local_val = spr_vr2;
      SPR_AVR:      local_val = spr_avr;
      default:      local_val = '0;
    endcase
  end

  // Result of the current access; a bus ack beats a simultaneous timeout.
  always_comb begin
    resp_fire  = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state)
      LOCAL: begin
        resp_fire  = 1'b1;
        resp_err   = we_q;
        resp_rdata = we_q ? '0 : local_val;
      end
      BUS: begin
        if (spr_bus_ack_i) begin
          resp_fire  = 1'b1;
          resp_rdata = we_q ? '0 : spr_bus_dat_i;
        end else if (cnt == TO_LAST) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      gnt_idx        <= CPU;
      we_q           <= 1'b0;
      lidx_q         <= '0;
      cnt            <= '0;
      cpu_ack_o      <= 1'b0;
      cpu_err_o      <= 1'b0;
      cpu_rdata_o    <= '0;
      du_ack_o       <= 1'b0;
      du_err_o       <= 1'b0;
      du_rdata_o     <= '0;
      spr_bus_stb_o  <= 1'b0;
      spr_bus_we_o   <= 1'b0;
      spr_bus_addr_o <= '0;
      spr_bus_dat_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            gnt_idx <= gnt[DU];
            we_q    <= sel_we;
            lidx_q  <= sel_addr[3:0];
            cnt     <= '0;
            if (is_local(sel_addr)) begin
              state <= LOCAL;
            end else begin
              state          <= BUS;
              spr_bus_stb_o  <= 1'b1;
              spr_bus_we_o   <= sel_we;
              spr_bus_addr_o <= sel_addr;
              spr_bus_dat_o  <= sel_wdata;
            end
          end
        end
        LOCAL: state <= RESP;
        BUS: begin
          if (resp_fire) begin
            state          <= RESP;
            spr_bus_stb_o  <= 1'b0;
            spr_bus_we_o   <= 1'b0;
            spr_bus_addr_o <= '0;
            spr_bus_dat_o  <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          cpu_ack_o   <= 1'b0;
          cpu_err_o   <= 1'b0;
          cpu_rdata_o <= '0;
          du_ack_o    <= 1'b0;
          du_err_o    <= 1'b0;
          du_rdata_o  <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Response registers are loaded on entry to RESP, so ack is visible
      // exactly during the RESP cycle.
      if (resp_fire) begin
        cpu_ack_o   <= (gnt_idx == CPU);
        cpu_err_o   <= (gnt_idx == CPU) && resp_err;
        cpu_rdata_o <= (gnt_idx == CPU) ? resp_rdata : '0;
        du_ack_o    <= (gnt_idx == DU);
        du_err_o    <= (gnt_idx == DU) && resp_err;
        du_rdata_o  <= (gnt_idx == DU) ? resp_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_or1k_spr_arbiter.sv
module tb_or1k_spr_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req_i, cpu_we_i, du_req_i, du_we_i;
  logic [15:0] cpu_addr_i, du_addr_i;
  logic [31:0] cpu_wdata_i, du_wdata_i;
  logic        cpu_ack_o, cpu_err_o, du_ack_o, du_err_o;
  logic [31:0] cpu_rdata_o, du_rdata_o;
  logic        spr_bus_stb_o, spr_bus_we_o, spr_bus_ack_i;
  logic [15:0] spr_bus_addr_o;
  logic [31:0] spr_bus_dat_o, spr_bus_dat_i;
  logic [31:0] cfg [0:10];

  always #5 clk = ~clk;

  or1k_spr_arbiter #(.OPTION_SPR_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o), .cpu_rdata_o(cpu_rdata_o),
    .du_req_i(du_req_i), .du_we_i(du_we_i), .du_addr_i(du_addr_i), .du_wdata_i(du_wdata_i),
    .du_ack_o(du_ack_o), .du_err_o(du_err_o), .du_rdata_o(du_rdata_o),
    .spr_vr(cfg[0]), .spr_upr(cfg[1]), .spr_cpucfgr(cfg[2]), .spr_dmmucfgr(cfg[3]),
    .spr_immucfgr(cfg[4]), .spr_dccfgr(cfg[5]), .spr_iccfgr(cfg[6]), .spr_dcfgr(cfg[7]),
    .spr_pccfgr(cfg[8]), .spr_vr2(cfg[9]), .spr_avr(cfg[10]),
    .spr_bus_stb_o(spr_bus_stb_o), .spr_bus_we_o(spr_bus_we_o),
    .spr_bus_addr_o(spr_bus_addr_o), .spr_bus_dat_o(spr_bus_dat_o),
    .spr_bus_ack_i(spr_bus_ack_i), .spr_bus_dat_i(spr_bus_dat_i)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int   nvec = 0;
  int   nerr = 0;
  bit   mlast = 1'b1;      // model of last-granted port: 0 cpu, 1 du
  int   bus_delay = 0;     // stb cycles before the bus acks (ack in stb cycle #bus_delay)
  logic [31:0] bus_data = '0;
  int   scnt = 0;

  assign spr_bus_dat_i = bus_data;

  // Downstream bus responder.
  initial begin
    spr_bus_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (spr_bus_stb_o) begin
        spr_bus_ack_i = (scnt == bus_delay);
        scnt++;
      end else begin
        spr_bus_ack_i = 1'b0;
        scnt = 0;
      end
    end
  end

  // ---- reference model ----
  function automatic bit is_loc(input logic [15:0] a);
    return (a >> 11) == 0 && (a & 16'h07FF) <= 10;
  endfunction

  function automatic bit bus_ok();
    return bus_delay < T;
  endfunction

  // Cycles from the IDLE-grant cycle to the ack cycle.
  function automatic int exp_lat(input txn_t t);
    if (is_loc(t.addr)) return 2;
    return bus_ok() ? bus_delay + 2 : T + 1;
  endfunction

  function automatic logic [31:0] exp_rdata(input txn_t t);
    if (is_loc(t.addr)) return t.we ? 32'h0 : cfg[int'(t.addr)];
    return (bus_ok() && !t.we) ? bus_data : 32'h0;
  endfunction

  function automatic bit exp_err(input txn_t t);
    if (is_loc(t.addr)) return t.we;
    return !bus_ok();
  endfunction

  function automatic int exp_stb(input txn_t t);
    if (is_loc(t.addr)) return 0;
    return bus_ok() ? bus_delay + 1 : T;
  endfunction

  function automatic txn_t mk(input bit we, input logic [15:0] a, input logic [31:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  // Issue one or two simultaneous requests and check order, latency, data.
  task automatic run(input bit en_c, input txn_t tc, input bit en_d, input txn_t td, input string tag);
    bit   first, dc, dd, p, ep;
    txn_t tf, ts, te;
    int   a1, a2, ec, stb_n, stb_exp;
    logic [31:0] rd;
    logic er;
    first = (en_c && en_d) ? ~mlast : en_d;
    tf = first ? td : tc;
    ts = first ? tc : td;
    a1 = exp_lat(tf);
    a2 = a1 + 1 + exp_lat(ts);
    stb_exp = exp_stb(tf) + ((en_c && en_d) ? exp_stb(ts) : 0);
    stb_n = 0;
    @(negedge clk);
    cpu_req_i = en_c; cpu_we_i = tc.we; cpu_addr_i = tc.addr; cpu_wdata_i = tc.wdata;
    du_req_i  = en_d; du_we_i  = td.we; du_addr_i  = td.addr; du_wdata_i  = td.wdata;
    dc = !en_c; dd = !en_d;
    for (int i = 1; i <= 60 && !(dc && dd); i++) begin
      @(posedge clk); #1;
      if (spr_bus_stb_o) stb_n++;
      nvec++;
      if (cpu_ack_o && du_ack_o) begin
        nerr++; $display("FAIL %s ack_overlap: cycle %0d both acks high, expected one", tag, i);
      end
      nvec++;
      if ((!cpu_ack_o && cpu_rdata_o !== 0) || (!du_ack_o && du_rdata_o !== 0) ||
          (!cpu_ack_o && cpu_err_o !== 0) || (!du_ack_o && du_err_o !== 0)) begin
        nerr++; $display("FAIL %s idle_resp: cycle %0d cpu rd=%h du rd=%h without ack, expected 0", tag, i, cpu_rdata_o, du_rdata_o);
      end
      if (cpu_ack_o || du_ack_o) begin
        p  = du_ack_o && !cpu_ack_o;
        ep = (first ? !dd : !dc) ? first : ~first;
        ec = (ep == first) ? a1 : a2;
        te = (ep == first) ? tf : ts;
        rd = p ? du_rdata_o : cpu_rdata_o;
        er = p ? du_err_o : cpu_err_o;
        nvec++;
        if (p !== ep || i != ec) begin
          nerr++; $display("FAIL %s order: port %0d at cycle %0d, expected port %0d at cycle %0d", tag, p, i, ep, ec);
        end
        nvec++;
        if (rd !== exp_rdata(te)) begin
          nerr++; $display("FAIL %s rdata: got %h expected %h", tag, rd, exp_rdata(te));
        end
        nvec++;
        if (er !== exp_err(te)) begin
          nerr++; $display("FAIL %s err: got %b expected %b", tag, er, exp_err(te));
        end
        if (p) begin du_req_i = 1'b0; dd = 1'b1; end
        else   begin cpu_req_i = 1'b0; dc = 1'b1; end
        mlast = p;
      end
    end
    nvec++;
    if (!(dc && dd)) begin
      nerr++; $display("FAIL %s ack_timeout: ack missing after 60 cycles, expected ack", tag);
    end
    cpu_req_i = 1'b0; du_req_i = 1'b0;
    nvec++;
    if (stb_n != stb_exp) begin
      nerr++; $display("FAIL %s stb_cycles: got %0d expected %0d", tag, stb_n, stb_exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_quiet(input string tag);
    nvec++;
    if ({cpu_ack_o, cpu_err_o, cpu_rdata_o, du_ack_o, du_err_o, du_rdata_o,
         spr_bus_stb_o, spr_bus_we_o, spr_bus_addr_o, spr_bus_dat_o} !== '0) begin
      nerr++; $display("FAIL %s outputs: cpu ack=%b rd=%h du ack=%b rd=%h stb=%b addr=%h, expected all 0",
                       tag, cpu_ack_o, cpu_rdata_o, du_ack_o, du_rdata_o, spr_bus_stb_o, spr_bus_addr_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_quiet("reset_held");
    @(negedge clk) rst_n = 1'b1;
    mlast = 1'b1;
    @(posedge clk); #1 check_quiet("reset_release");
  endtask

  task automatic test_local();
    cfg[2] = 32'h0000_0720;
    run(1, mk(0, 16'h0002, 0), 0, mk(0, 0, 0), "cpucfgr_read");
    cfg[1] = 32'h1234_5678;
    run(0, mk(0, 0, 0), 1, mk(1, 16'h0001, 32'hFFFF_FFFF), "upr_write");
    run(0, mk(0, 0, 0), 1, mk(0, 16'h0001, 0), "upr_readback");
    run(1, mk(0, 16'h000A, 0), 0, mk(0, 0, 0), "avr_edge");
    run(1, mk(0, 16'h0000, 0), 0, mk(0, 0, 0), "vr_edge");
  endtask

  task automatic test_bus();
    bus_delay = 2; bus_data = 32'hDEAD_BEEF;
    run(1, mk(0, 16'h5011, 0), 0, mk(0, 0, 0), "bus_read");
    bus_delay = 0; bus_data = 32'h0BAD_F00D;
    run(1, mk(0, 16'h000B, 0), 0, mk(0, 0, 0), "idx11_bus");
    run(0, mk(0, 0, 0), 1, mk(1, 16'h0800, 32'h55AA_55AA), "bus_write");
    bus_delay = T - 1; bus_data = 32'hCAFE_0001;
    run(1, mk(0, 16'h0801, 0), 0, mk(0, 0, 0), "ack_at_limit");
  endtask

  task automatic test_timeout();
    bus_delay = 100; bus_data = 32'h1111_2222;
    run(0, mk(0, 0, 0), 1, mk(0, 16'h2800, 0), "timeout");
  endtask

  task automatic test_back_to_back();
    test_reset();
    cfg[0] = 32'hA5A5_0001; cfg[9] = 32'h0000_0099;
    bus_delay = 1; bus_data = 32'h7777_8888;
    run(1, mk(0, 16'h0000, 0), 1, mk(0, 16'h0009, 0), "tie1");
    run(1, mk(0, 16'h4000, 0), 1, mk(0, 16'h0009, 0), "tie2");
  endtask

  task automatic test_reset_mid_bus();
    bus_delay = 100;
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 16'h5011;
    @(posedge clk); #1;
    nvec++;
    if (spr_bus_stb_o !== 1'b1) begin
      nerr++; $display("FAIL rst_mid stb_before: got %b expected 1", spr_bus_stb_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check_quiet("rst_mid_async");
    cpu_req_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    mlast = 1'b1;
    @(posedge clk); #1 check_quiet("rst_mid_after");
    bus_delay = 1; bus_data = 32'h3C3C_4B4B;
    run(1, mk(0, 16'h5011, 0), 0, mk(0, 0, 0), "rst_mid_recover");
  endtask

  task automatic test_random();
    txn_t tc, td;
    bit ec, ed;
    logic [15:0] a;
    for (int k = 0; k < 11; k++) cfg[k] = $urandom;
    for (int n = 0; n < 40; n++) begin
      ec = $urandom_range(0, 1);
      ed = $urandom_range(0, 1);
      if (!ec && !ed) ec = 1'b1;
      a = $urandom_range(0, 1) ? 16'($urandom_range(0, 12)) : 16'($urandom);
      tc = mk($urandom_range(0, 1), a, $urandom);
      a = $urandom_range(0, 1) ? 16'($urandom_range(0, 12)) : 16'($urandom);
      td = mk($urandom_range(0, 1), a, $urandom);
      bus_delay = $urandom_range(0, 6);
      bus_data = $urandom;
      run(ec, tc, ed, td, "random");
    end
  endtask

  initial begin
    cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
    du_req_i = 0; du_we_i = 0; du_addr_i = 0; du_wdata_i = 0;
    for (int k = 0; k < 11; k++) cfg[k] = 32'h100 + k;
    test_reset();
    test_local();
    test_bus();
    test_timeout();
    test_back_to_back();
    test_reset_mid_bus();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
